// File: rtl/alien_pkg.sv
// Shared alien formation geometry and types; the renderer imports the same
// constants so the drawn boxes and the hit boxes can never drift apart.
package alien_pkg;

  localparam int ALIENS_WIDTH  = 20;
  localparam int ALIENS_HEIGHT = 10;
  localparam int COL_PITCH     = 40;
  localparam int ROW_PITCH     = 20;
  localparam int NUM_ROWS      = 4;
  localparam int NUM_COLS      = 8;
  localparam int NUM_ALIENS    = NUM_ROWS * NUM_COLS;
  localparam int HALF_W        = ALIENS_WIDTH / 2;
  localparam int HALF_H        = ALIENS_HEIGHT / 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_CLEARED = 2'd1,
    ST_LANDED  = 2'd2
  } fleet_state_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } fleet_dir_t;

endpackage

// File: rtl/alien_hit_detect.sv
// Combinational 32-way compare of a shot pixel against every live alien box.
// Boxes are open intervals, so a pixel exactly on a box edge is a miss.
module alien_hit_detect
  import alien_pkg::*;
(
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic [9:0]            shot_x,
  input  logic [9:0]            shot_y,
  input  logic [NUM_ALIENS-1:0] alive,
  output logic                  match,
  output logic [4:0]            index
);

  // Comparisons are rearranged to stay unsigned: shot+half > origin is shot > origin-half.
  always_comb begin
    match = 1'b0;
    index = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      for (int j = 0; j < NUM_COLS; j++) begin
        if (alive[NUM_COLS*i+j]
            && ({2'b0, shot_x} + 12'(HALF_W) > {2'b0, x} + 12'(COL_PITCH*j))
            && ({2'b0, shot_x} < {2'b0, x} + 12'(COL_PITCH*j + HALF_W))
            && ({2'b0, shot_y} + 12'(HALF_H) > {2'b0, y} + 12'(ROW_PITCH*i))
            && ({2'b0, shot_y} < {2'b0, y} + 12'(ROW_PITCH*i + HALF_H))) begin
          match = 1'b1;
          index = 5'(NUM_COLS*i + j);
        end
      end
    end
  end

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Alien fleet owner: marching, edge descents, shot resolution and end states.
// Define ALIEN_SPEEDUP_EN to shorten the step period as the fleet thins out.
module alien_fleet_ctrl
  import alien_pkg::*;
#(
  parameter int X_START     = 100,
  parameter int Y_START     = 40,
  parameter int X_STEP      = 4,
  parameter int Y_STEP      = 10,
  parameter int STEP_FRAMES = 30,
  parameter int H_MIN       = 8,
  parameter int H_MAX       = 632,
  parameter int LAND_Y      = 440
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frameTick,
  input  logic        restart,
  input  logic        shotValid,
  input  logic [9:0]  shotX,
  input  logic [9:0]  shotY,
  output logic [9:0]  xAlien,
  output logic [9:0]  yAlien,
  output logic [31:0] alive,
  output logic        shotHit,
  output logic [4:0]  hitIndex,
  output logic        allDead,
  output logic        landed
);

  localparam int DIV_W = $clog2(STEP_FRAMES);

  fleet_state_t          state, state_next;
  fleet_dir_t            dir;
  logic [9:0]            x, y;
  logic [NUM_ALIENS-1:0] alive_q;
  logic [DIV_W-1:0]      div, period_m1;
  logic                  s1_valid;
  logic [9:0]            s1_x, s1_y;
  logic                  shot_hit_q;
  logic [4:0]            hit_index_q;
  logic                  match;
  logic [4:0]            match_index;
  logic                  hit_fire, tick_run;
  logic [NUM_COLS-1:0]   col_any;
  logic [NUM_ROWS-1:0]   row_any;
  logic [2:0]            r_col, l_col;
  logic [1:0]            b_row;
  logic [11:0]           r_edge, bottom;
  logic signed [11:0]    l_edge;
  logic                  at_right, at_left, reached_land;

`ifdef ALIEN_SPEEDUP_EN
  localparam int PERIOD_HALF    = STEP_FRAMES / 2;
  localparam int PERIOD_QUARTER = (STEP_FRAMES / 4 < 1) ? 1 : STEP_FRAMES / 4;
  logic [5:0] live_count;

  always_comb begin
    live_count = '0;
    for (int k = 0; k < NUM_ALIENS; k++) live_count = live_count + 6'(alive_q[k]);
    if (live_count <= 6'd2)      period_m1 = DIV_W'(PERIOD_QUARTER - 1);
    else if (live_count <= 6'd8) period_m1 = DIV_W'(PERIOD_HALF - 1);
    else                         period_m1 = DIV_W'(STEP_FRAMES - 1);
  end
`else
  assign period_m1 = DIV_W'(STEP_FRAMES - 1);
`endif

  alien_hit_detect u_hit (
    .x      (x),
    .y      (y),
    .shot_x (s1_x),
    .shot_y (s1_y),
    .alive  (alive_q),
    .match  (match),
    .index  (match_index)
  );

  // Extreme live columns/row drive the edge tests, so dead columns do not stop the march.
  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int i = 0; i < NUM_ROWS; i++)
      for (int j = 0; j < NUM_COLS; j++)
        if (alive_q[NUM_COLS*i+j]) begin
          col_any[j] = 1'b1;
          row_any[i] = 1'b1;
        end
    r_col = '0;
    l_col = '0;
    b_row = '0;
    for (int j = 0; j < NUM_COLS; j++) if (col_any[j]) r_col = 3'(j);
    for (int j = NUM_COLS-1; j >= 0; j--) if (col_any[j]) l_col = 3'(j);
    for (int i = 0; i < NUM_ROWS; i++) if (row_any[i]) b_row = 2'(i);
  end

  assign r_edge       = {2'b0, x} + 12'(HALF_W) + 12'(COL_PITCH) * {9'b0, r_col};
  assign l_edge       = $signed({2'b0, x} + 12'(COL_PITCH) * {9'b0, l_col}) - $signed(12'(HALF_W));
  assign at_right     = (r_edge + 12'(X_STEP)) > 12'(H_MAX);
  assign at_left      = (l_edge - $signed(12'(X_STEP))) < $signed(12'(H_MIN));
  assign bottom       = {2'b0, y} + 12'(HALF_H) + 12'(ROW_PITCH) * {10'b0, b_row};
  assign reached_land = bottom >= 12'(LAND_Y);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    hit_fire   = 1'b0;
    tick_run   = 1'b0;
    if (restart) begin
      state_next = ST_RUN;
    end else if (state == ST_RUN) begin
      hit_fire = s1_valid && match;
      tick_run = frameTick;
      if (alive_q == '0)     state_next = ST_CLEARED;
      else if (reached_land) state_next = ST_LANDED;
    end
  end

  // Hit and step both read pre-edge x/y/alive, so a coincident pair commits cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x           <= 10'(X_START);
      y           <= 10'(Y_START);
      alive_q     <= '1;
      dir         <= DIR_RIGHT;
      div         <= '0;
      s1_valid    <= 1'b0;
      s1_x        <= '0;
      s1_y        <= '0;
      shot_hit_q  <= 1'b0;
      hit_index_q <= '0;
    end else if (restart) begin
      x           <= 10'(X_START);
      y           <= 10'(Y_START);
      alive_q     <= '1;
      dir         <= DIR_RIGHT;
      div         <= '0;
      s1_valid    <= 1'b0;
      s1_x        <= '0;
      s1_y        <= '0;
      shot_hit_q  <= 1'b0;
      hit_index_q <= '0;
    end else begin
      s1_valid   <= shotValid;
      s1_x       <= shotX;
      s1_y       <= shotY;
      shot_hit_q <= hit_fire;
      if (hit_fire) begin
        alive_q     <= alive_q & ~(32'd1 << match_index);
        hit_index_q <= match_index;
      end
      if (tick_run) begin
        if (div >= period_m1) begin
          div <= '0;
          if (alive_q != '0) begin
            if (dir == DIR_RIGHT) begin
              if (at_right) begin
                y   <= y + 10'(Y_STEP);
                dir <= DIR_LEFT;
              end else begin
                x <= x + 10'(X_STEP);
              end
            end else begin
              if (at_left) begin
                y   <= y + 10'(Y_STEP);
                dir <= DIR_RIGHT;
              end else begin
                x <= x - 10'(X_STEP);
              end
            end
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

  assign xAlien   = x;
  assign yAlien   = y;
  assign alive    = alive_q;
  assign shotHit  = shot_hit_q;
  assign hitIndex = hit_index_q;
  assign allDead  = (state == ST_CLEARED);
  assign landed   = (state == ST_LANDED);

endmodule
